// File: rtl/square_tone_gen.sv
// Square-wave tone generator: plays one note (or rest) of half_period/dur_ms; start accepted only when ready.
// Wave and done are registered; done fires on the edge the final tick expires; busy blocks new starts.
module square_tone_gen #(
    parameter int MS_DIV = 100000,
    parameter int HP_W   = 18,
    parameter int DUR_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [HP_W-1:0]  half_period,
    input  logic [DUR_W-1:0] dur_ms,
    output logic             ready,
    output logic             busy,
    output logic             wave,
    output logic             done
);
    localparam int PS_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(MS_DIV - 1);
    localparam logic [HP_W-1:0]  HP_ONE  = HP_W'(1);
    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t           state;
    logic [HP_W-1:0]  hp_q;
    logic [HP_W-1:0]  phase;
    logic [PS_W-1:0]  presc;
    logic [DUR_W-1:0] remaining;

    assign ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            wave      <= 1'b0;
            done      <= 1'b0;
            hp_q      <= '0;
            phase     <= '0;
            presc     <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hp_q      <= half_period;
                        remaining <= dur_ms;
                        phase     <= '0;
                        presc     <= '0;
                        wave      <= 1'b0;
                        if (dur_ms == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= PLAY;
                            busy  <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        wave  <= 1'b0;
                    end else begin
                        // A zero half-period is a rest: phase and wave stay frozen at 0.
                        if (hp_q != '0) begin
                            if (phase == hp_q - HP_ONE) begin
                                phase <= '0;
                                wave  <= ~wave;
                            end else begin
                                phase <= phase + HP_ONE;
                            end
                        end
                        if (presc == PS_LAST) begin
                            presc     <= '0;
                            remaining <= remaining - DUR_ONE;
                            // Final tick: these later assignments override the toggle above.
                            if (remaining == DUR_ONE) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                wave  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PS_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    wave  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_square_tone_gen.sv
// Bench for square_tone_gen with MS_DIV=10: directed corner cases plus random notes against a timing model.
module tb_square_tone_gen;
    localparam int MS_DIV = 10;
    localparam int HP_W   = 6;
    localparam int DUR_W  = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic [HP_W-1:0]  half_period;
    logic [DUR_W-1:0] dur_ms;
    logic             ready;
    logic             busy;
    logic             wave;
    logic             done;

    int total;
    int bad;

    square_tone_gen #(.MS_DIV(MS_DIV), .HP_W(HP_W), .DUR_W(DUR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .half_period(half_period), .dur_ms(dur_ms),
        .ready(ready), .busy(busy), .wave(wave), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, observed, expected, $time);
        end
    endtask

    // k counts clock edges after the accepting edge (k=0 is the accepting edge itself).
    // Reference: busy for k<N with N=dur*MS_DIV, wave = (k/hp) odd, done at k==N,
    // stop driven after sample stop_k ends the note at edge stop_k+1 without done.
    task automatic run_note(input int hp, input int dur, input int stop_k, input int inj_k,
                            input bit with_stop);
        int  n;
        int  last_k;
        bit  exp_busy;
        bit  exp_wave;
        bit  exp_done;
        bit  stopped;
        n      = dur * MS_DIV;
        last_k = (stop_k >= 0) ? stop_k + 1 : n;
        @(negedge clk);
        start       = 1'b1;
        stop        = with_stop;
        half_period = HP_W'(hp);
        dur_ms      = DUR_W'(dur);
        for (int k = 0; k <= last_k; k++) begin
            @(posedge clk);
            #1;
            stopped  = (stop_k >= 0) && (k > stop_k);
            exp_busy = (k < n) && !stopped;
            exp_wave = exp_busy && (hp > 0) && (((k / (hp > 0 ? hp : 1)) % 2) == 1);
            exp_done = (k == n) && !stopped;
            check($sformatf("busy hp=%0d dur=%0d k=%0d", hp, dur, k), busy, exp_busy);
            check($sformatf("wave hp=%0d dur=%0d k=%0d", hp, dur, k), wave, exp_wave);
            check($sformatf("done hp=%0d dur=%0d k=%0d", hp, dur, k), done, exp_done);
            check($sformatf("ready hp=%0d dur=%0d k=%0d", hp, dur, k), ready, !exp_busy);
            if (k < last_k) begin
                @(negedge clk);
                start = (k == inj_k);
                stop  = (k == stop_k);
                if (k == inj_k) begin
                    half_period = HP_W'((hp + 1) % 8);
                    dur_ms      = DUR_W'($urandom_range(1, 15));
                end
            end
        end
    endtask

    initial begin
        int hp;
        int dur;
        int n;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        half_period = '0;
        dur_ms      = '0;

        // Reset state, including a start request held during reset.
        repeat (2) @(posedge clk);
        start = 1'b1;
        #1;
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wave", wave, 1'b0);
        check("rst_done", done, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("post_rst_ready", ready, 1'b1);

        // Directed cases.
        run_note(3, 2, -1, -1, 1'b0);       // basic tone
        run_note(0, 3, -1, -1, 1'b0);       // rest
        run_note(2, 0, -1, -1, 1'b0);       // zero duration
        run_note(3, 5, 7, -1, 1'b0);        // stop mid-note
        run_note(3, 2, -1, -1, 1'b0);       // accepted right after stop
        run_note(3, 2, -1, 4, 1'b0);        // start during PLAY ignored
        run_note(2, 2, 19, -1, 1'b0);       // stop on the final tick edge
        run_note(1, 1, -1, -1, 1'b1);       // start+stop in IDLE
        run_note(63, 15, -1, -1, 1'b0);     // maximum half-period and duration
        run_note(1, 2, -1, -1, 1'b0);       // fastest toggle

        // Asynchronous reset mid-note while wave is high.
        @(negedge clk);
        start       = 1'b1;
        stop        = 1'b0;
        half_period = HP_W'(3);
        dur_ms      = DUR_W'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_arst_wave", wave, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_wave", wave, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", ready, 1'b0);
        check("arst_done", done, 1'b0);
        @(posedge clk);
        #1;
        check("arst_hold_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_release_ready", ready, 1'b1);
        run_note(2, 1, -1, -1, 1'b0);

        // Random notes, some aborted, some with ignored starts.
        for (int i = 0; i < 30; i++) begin
            hp  = $urandom_range(0, 7);
            dur = $urandom_range(0, 6);
            n   = dur * MS_DIV;
            if (n > 2 && $urandom_range(0, 3) == 0)
                run_note(hp, dur, $urandom_range(0, n - 1), -1, 1'b0);
            else if (n > 2 && $urandom_range(0, 2) == 0)
                run_note(hp, dur, -1, $urandom_range(0, n - 2), 1'b0);
            else
                run_note(hp, dur, -1, -1, 1'b0);
        end

        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
